// File: rtl/ccr_unit_pkg.sv
// ccr_unit_pkg
//   Shared definitions for the condition-code register stage:
//   CCR bit positions, jump-type codes and a flag-packing helper.
package ccr_unit_pkg;

  localparam int CCR_ZF = 0;
  localparam int CCR_CF = 1;
  localparam int CCR_OF = 2;
  localparam int CCR_NF = 3;

  typedef enum logic [1:0] {
    JT_NONE = 2'b00,
    JT_JZ   = 2'b01,
    JT_JN   = 2'b10,
    JT_JC   = 2'b11
  } jump_type_e;

  // Packs individual ALU flags into CCR layout [3 NF, 2 OF, 1 CF, 0 ZF].
  function automatic logic [3:0] pack_flags(input logic nf, input logic of_flag,
                                            input logic cf, input logic zf);
    logic [3:0] ccr;
    ccr         = '0;
    ccr[CCR_NF] = nf;
    ccr[CCR_OF] = of_flag;
    ccr[CCR_CF] = cf;
    ccr[CCR_ZF] = zf;
    return ccr;
  endfunction

endpackage

// File: rtl/ccr_unit_if.sv
// ccr_unit_if
//   Bundle between the execute stage (master: ALU / pipeline control) and the
//   CCR stage (slave).
//   master drives : ccr_write, stall, flush, zf_in/cf_in/of_in/nf_in,
//                   freeze_push, freeze_pop, jump_type
//   slave drives  : zero_flag, carry_flag, over_flow_flag, negative_flag,
//                   freezed_ccr, jump_taken, freeze_empty, freeze_full, freeze_err
interface ccr_unit_if;
  logic       ccr_write;
  logic       stall;
  logic       flush;
  logic       zf_in;
  logic       cf_in;
  logic       of_in;
  logic       nf_in;
  logic       freeze_push;
  logic       freeze_pop;
  logic [1:0] jump_type;

  logic       zero_flag;
  logic       carry_flag;
  logic       over_flow_flag;
  logic       negative_flag;
  logic [3:0] freezed_ccr;
  logic       jump_taken;
  logic       freeze_empty;
  logic       freeze_full;
  logic       freeze_err;

  modport master (
    output ccr_write, stall, flush, zf_in, cf_in, of_in, nf_in,
           freeze_push, freeze_pop, jump_type,
    input  zero_flag, carry_flag, over_flow_flag, negative_flag,
           freezed_ccr, jump_taken, freeze_empty, freeze_full, freeze_err
  );

  modport slave (
    input  ccr_write, stall, flush, zf_in, cf_in, of_in, nf_in,
           freeze_push, freeze_pop, jump_type,
    output zero_flag, carry_flag, over_flow_flag, negative_flag,
           freezed_ccr, jump_taken, freeze_empty, freeze_full, freeze_err
  );
endinterface

// File: rtl/ccr_freeze_stack.sv
// ccr_freeze_stack
//   LIFO of 4-bit CCR snapshots used for nested interrupts.
//   Ports:
//     clk, rst_n  clock, async active-low reset
//     push_i      push data_i (or overwrite the top when popped together)
//     pop_i       pop the top entry
//     data_i      snapshot to store
//     top_o       registered top entry, 0 while empty
//     empty_o     no entries held
//     full_o      DEPTH entries held
//     err_o       sticky: push when full or pop when empty
module ccr_freeze_stack #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [3:0] data_i,
  output logic [3:0] top_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       err_o
);

  localparam int IW = $clog2(DEPTH);
  // One extra bit so that depth==DEPTH is distinct from depth==0.
  localparam int PW = IW + 1;

  logic [PW-1:0] depth_q, depth_d;
  logic          err_q, err_d;
  logic [3:0]    mem_q [DEPTH];
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;

  assign empty_o = (depth_q == '0);
  assign full_o  = (depth_q == PW'(DEPTH));
  assign top_idx = IW'(depth_q - PW'(1));
  assign err_o   = err_q;
  // Storage is not cleared on reset, so the top must be masked while empty.
  assign top_o   = empty_o ? 4'b0000 : mem_q[top_idx];

  always_comb begin
    depth_d = depth_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_idx  = depth_q[IW-1:0];
    if (push_i && pop_i && !empty_o) begin
      // RTI and interrupt in the same cycle: replace the top in place.
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push_i) begin
      if (!full_o) begin
        wr_en   = 1'b1;
        depth_d = depth_q + PW'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (pop_i) begin
      if (!empty_o) begin
        depth_d = depth_q - PW'(1);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/ccr_unit.sv
// ccr_unit
//   Condition-code register stage behind the EX-stage ALU. Holds the
//   architectural flags, a LIFO of frozen snapshots for nested interrupts,
//   and resolves conditional-jump conditions from the registered flags.
//   Ports:
//     clk, rst_n  clock, async active-low reset
//     bus         ccr_unit_if.slave (flag inputs, stall/flush, freeze
//                 push/pop, jump type in; flags, freezed_ccr, jump_taken,
//                 stack status out)
module ccr_unit
  import ccr_unit_pkg::*;
#(
  parameter int FREEZE_DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  ccr_unit_if.slave bus
);

  logic [3:0] flags_q, flags_d;
  logic [3:0] flags_in;
  logic [3:0] snapshot;
  logic       wr_en;
  logic       push_en;
  logic       pop_en;

  // stall blocks everything; flush only kills the flag commit.
  assign wr_en   = bus.ccr_write & ~bus.stall & ~bus.flush;
  assign push_en = bus.freeze_push & ~bus.stall;
  assign pop_en  = bus.freeze_pop & ~bus.stall;

  assign flags_in = pack_flags(bus.nf_in, bus.of_in, bus.cf_in, bus.zf_in);
  assign flags_d  = wr_en ? flags_in : flags_q;
  // Snapshot the post-commit value so the interrupted instruction's flags survive.
  assign snapshot = flags_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  ccr_freeze_stack #(
    .DEPTH (FREEZE_DEPTH)
  ) u_freeze_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_en),
    .pop_i   (pop_en),
    .data_i  (snapshot),
    .top_o   (bus.freezed_ccr),
    .empty_o (bus.freeze_empty),
    .full_o  (bus.freeze_full),
    .err_o   (bus.freeze_err)
  );

  assign bus.zero_flag      = flags_q[CCR_ZF];
  assign bus.carry_flag     = flags_q[CCR_CF];
  assign bus.over_flow_flag = flags_q[CCR_OF];
  assign bus.negative_flag  = flags_q[CCR_NF];

  // Registered flags only; same-cycle flag hazards are resolved by stalling.
  always_comb begin
    bus.jump_taken = 1'b0;
    case (bus.jump_type)
      JT_JZ:   bus.jump_taken = flags_q[CCR_ZF];
      JT_JN:   bus.jump_taken = flags_q[CCR_NF];
      JT_JC:   bus.jump_taken = flags_q[CCR_CF];
      default: bus.jump_taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ccr_unit.sv
module tb_ccr_unit;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ccr_unit_if bus ();

  ccr_unit #(.FREEZE_DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  // Reference state: flags as a nibble {NF,OF,CF,ZF}, stack as a queue.
  logic [3:0] m_flags;
  logic [3:0] m_stack[$];
  bit         m_err;

  // Expected observation: {flags[3:0], top[3:0], empty, full, err, jump}
  logic [11:0] exp_q[$];

  function automatic logic [11:0] observe_dut();
    return {bus.negative_flag, bus.over_flow_flag, bus.carry_flag, bus.zero_flag,
            bus.freezed_ccr, bus.freeze_empty, bus.freeze_full, bus.freeze_err,
            bus.jump_taken};
  endfunction

  function automatic logic [11:0] model_obs(input logic [1:0] jt);
    logic [3:0] top;
    logic       jmp;
    top = (m_stack.size() > 0) ? m_stack[m_stack.size()-1] : 4'b0000;
    case (jt)
      2'b01:   jmp = m_flags[0];
      2'b10:   jmp = m_flags[3];
      2'b11:   jmp = m_flags[1];
      default: jmp = 1'b0;
    endcase
    return {m_flags, top, m_stack.size() == 0, m_stack.size() == D, m_err, jmp};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got flags=%b top=%b e/f/err/j=%b want flags=%b top=%b e/f/err/j=%b",
               name, act[11:8], act[7:4], act[3:0], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic check_bits(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a new state just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [11:0] e;
      e = exp_q.pop_front();
      check("cycle", observe_dut(), e);
    end
  end

  task automatic idle_inputs();
    bus.ccr_write = 0; bus.stall = 0; bus.flush = 0;
    {bus.nf_in, bus.of_in, bus.cf_in, bus.zf_in} = 4'b0000;
    bus.freeze_push = 0; bus.freeze_pop = 0; bus.jump_type = 2'b00;
  endtask

  task automatic step(input logic cw, input logic st, input logic fl, input logic [3:0] din,
                      input logic push, input logic pop, input logic [1:0] jt);
    bit wr, pu, po;
    logic [3:0] snap;
    @(negedge clk);
    bus.ccr_write = cw; bus.stall = st; bus.flush = fl;
    {bus.nf_in, bus.of_in, bus.cf_in, bus.zf_in} = din;
    bus.freeze_push = push; bus.freeze_pop = pop; bus.jump_type = jt;
    wr = cw && !st && !fl;
    pu = push && !st;
    po = pop && !st;
    snap = wr ? din : m_flags;
    if (pu && po && m_stack.size() > 0) begin
      m_stack[m_stack.size()-1] = snap;
    end else if (pu) begin
      if (m_stack.size() < D) m_stack.push_back(snap);
      else m_err = 1;
    end else if (po) begin
      if (m_stack.size() > 0) void'(m_stack.pop_back());
      else m_err = 1;
    end
    if (wr) m_flags = din;
    exp_q.push_back(model_obs(jt));
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    m_flags = 4'b0000;
    m_stack.delete();
    m_err = 0;
    repeat (2) @(negedge clk);
    check("reset", observe_dut(), {4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});
    rst_n = 1;
  endtask

  initial begin
    idle_inputs();
    m_flags = 4'b0000;
    m_err = 0;
    do_reset();

    // Flag commit, then stall and flush must both block the write.
    step(1, 0, 0, 4'b1011, 0, 0, 2'b01);
    check_bits("commit_flags", observe_dut() >> 8, 4'b1011);
    check_bits("jz_taken", {3'b000, bus.jump_taken}, 4'b0001);
    step(1, 1, 0, 4'b0000, 0, 0, 2'b10);
    check_bits("stall_hold", observe_dut() >> 8, 4'b1011);
    step(1, 0, 1, 4'b0000, 0, 0, 2'b11);
    check_bits("flush_hold", observe_dut() >> 8, 4'b1011);

    // Nested freeze of depth 2.
    step(1, 0, 0, 4'b0101, 0, 0, 2'b00);
    step(0, 0, 0, 4'b0000, 1, 0, 2'b00);
    step(1, 0, 0, 4'b1010, 0, 0, 2'b00);
    step(0, 0, 0, 4'b0000, 1, 0, 2'b00);
    check_bits("nest_top", bus.freezed_ccr, 4'b1010);
    step(0, 0, 0, 4'b0000, 0, 1, 2'b00);
    check_bits("pop1_top", bus.freezed_ccr, 4'b0101);
    step(0, 0, 0, 4'b0000, 0, 1, 2'b00);
    check_bits("pop2_top", {bus.freeze_empty, 3'b000} | {1'b0, bus.freezed_ccr[2:0]}, 4'b1000);

    // Push with same-cycle write captures the committed flags.
    step(1, 0, 0, 4'b0000, 0, 0, 2'b00);
    step(1, 0, 0, 4'b0110, 1, 0, 2'b00);
    check_bits("push_bypass_top", bus.freezed_ccr, 4'b0110);
    check_bits("push_bypass_flags", observe_dut() >> 8, 4'b0110);

    // Overflow: five pushes into an empty depth-4 stack.
    do_reset();
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 4'(i), 1, 0, 2'b00);
    check_bits("full_flags", {bus.freeze_full, bus.freeze_err, 2'b00}, 4'b1100);
    check_bits("full_top", bus.freezed_ccr, 4'b0100);

    // Underflow right after reset.
    do_reset();
    step(0, 0, 0, 4'b0000, 0, 1, 2'b00);
    check_bits("underflow", {bus.freeze_empty, bus.freeze_err, 2'b00}, 4'b1100);

    // Async reset between edges with depth 3 and flags 1111.
    do_reset();
    step(1, 0, 0, 4'b1111, 1, 0, 2'b00);
    step(0, 0, 0, 4'b0000, 1, 0, 2'b00);
    step(0, 0, 0, 4'b0000, 1, 0, 2'b00);
    #1;
    rst_n = 0;
    #1;
    check("async_reset", observe_dut(), {4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});
    do_reset();

    // Randomized phase, with resets between rounds so err can clear.
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 150; n++) begin
        step($urandom_range(99) < 70, $urandom_range(99) < 15, $urandom_range(99) < 10,
             4'($urandom), $urandom_range(99) < 35, $urandom_range(99) < 28,
             2'($urandom));
      end
      do_reset();
    end

    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
